// File: rtl/stall4mem_ctrl_fsm.sv
// stall4mem_ctrl_fsm: fetch/execute/load/store sequencer with memory stalls, counters and sticky trap.
// Optional memory-wait watchdog compiled in with `define MEM_TIMEOUT_EN.
`default_nettype none

module stall4mem_ctrl_fsm #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_ready_i,
  input  logic                 dmem_ready_i,
  input  logic [2:0]           instr_class_i,
  output logic                 read_instr_o,
  output logic                 instr_latch_o,
  output logic                 dmem_read_o,
  output logic                 dmem_write_o,
  output logic                 pc_we_o,
  output logic                 rf_we_o,
  output logic                 rf_wsel_o,
  output logic                 instret_o,
  output logic                 trap_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o
);

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_UPPER  = 3'd5;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    LOAD_REQ   = 3'd3,
    LOAD_WAIT  = 3'd4,
    STORE_REQ  = 3'd5,
    STORE_WAIT = 3'd6,
    TRAP       = 3'd7
  } state_t;

  state_t state, next_state;
  logic   timeout_hit;

  if (CNT_WIDTH < 8 || TIMEOUT_CYCLES < 2 || TO_WIDTH < 2) begin : g_param_check
    $error("stall4mem_ctrl_fsm: illegal parameter combination");
  end

`ifdef MEM_TIMEOUT_EN
  logic                in_wait;
  logic                wait_ready;
  logic [TO_WIDTH-1:0] wait_cnt;

  assign in_wait    = (state == FETCH_WAIT) || (state == LOAD_WAIT) || (state == STORE_WAIT);
  assign wait_ready = (state == FETCH_WAIT) ? instr_ready_i : dmem_ready_i;
  // Fires on the TIMEOUT_CYCLES-th unanswered wait cycle; a ready on that cycle wins.
  assign timeout_hit = in_wait && !wait_ready && (wait_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (!in_wait)
        wait_cnt <= '0;
      else if (!wait_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        timeout_o <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_REQ;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    read_instr_o  = 1'b0;
    instr_latch_o = 1'b0;
    dmem_read_o   = 1'b0;
    dmem_write_o  = 1'b0;
    pc_we_o       = 1'b0;
    rf_we_o       = 1'b0;
    rf_wsel_o     = 1'b0;
    instret_o     = 1'b0;
    case (state)
      FETCH_REQ: begin
        read_instr_o = 1'b1;
        next_state   = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (instr_ready_i) begin
          instr_latch_o = 1'b1;
          next_state    = EXEC;
        end else if (timeout_hit) begin
          next_state = TRAP;
        end
      end
      EXEC: begin
        case (instr_class_i)
          CLS_ALU, CLS_JUMP, CLS_UPPER: begin
            pc_we_o    = 1'b1;
            rf_we_o    = 1'b1;
            instret_o  = 1'b1;
            next_state = FETCH_REQ;
          end
          CLS_BRANCH: begin
            pc_we_o    = 1'b1;
            instret_o  = 1'b1;
            next_state = FETCH_REQ;
          end
          CLS_LOAD:  next_state = LOAD_REQ;
          CLS_STORE: next_state = STORE_REQ;
          default:   next_state = TRAP;
        endcase
      end
      LOAD_REQ: begin
        dmem_read_o = 1'b1;
        next_state  = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (dmem_ready_i) begin
          rf_we_o    = 1'b1;
          rf_wsel_o  = 1'b1;
          pc_we_o    = 1'b1;
          instret_o  = 1'b1;
          next_state = FETCH_REQ;
        end else if (timeout_hit) begin
          next_state = TRAP;
        end
      end
      STORE_REQ: begin
        dmem_write_o = 1'b1;
        next_state   = STORE_WAIT;
      end
      STORE_WAIT: begin
        if (dmem_ready_i) begin
          pc_we_o    = 1'b1;
          instret_o  = 1'b1;
          next_state = FETCH_REQ;
        end else if (timeout_hit) begin
          next_state = TRAP;
        end
      end
      TRAP:    next_state = TRAP;
      default: next_state = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_o        <= 1'b0;
      cycle_cnt_o   <= '0;
      instret_cnt_o <= '0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + 1'b1;
      if (instret_o)
        instret_cnt_o <= instret_cnt_o + 1'b1;
      if (next_state == TRAP)
        trap_o <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stall4mem_ctrl_fsm.sv
// Directed testbench for stall4mem_ctrl_fsm (CNT_WIDTH=8, TIMEOUT_CYCLES=8).
`default_nettype none

module tb_stall4mem_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_ready_i = 1'b0;
  logic       dmem_ready_i = 1'b0;
  logic [2:0] instr_class_i = 3'd0;
  logic       read_instr_o, instr_latch_o, dmem_read_o, dmem_write_o;
  logic       pc_we_o, rf_we_o, rf_wsel_o, instret_o, trap_o, timeout_o;
  logic [7:0] cycle_cnt_o, instret_cnt_o;
  logic [7:0] strobes;

  int   errors = 0;
  int   checks = 0;
  int   exp_cycle = 0;
  int   exp_instret = 0;
  logic exp_trap = 1'b0;
  logic exp_timeout = 1'b0;

  // Strobe bit order: read_instr, latch, dmem_read, dmem_write, pc_we, rf_we, rf_wsel, instret
  localparam logic [7:0] S_NONE  = 8'h00;
  localparam logic [7:0] S_FREQ  = 8'h80;
  localparam logic [7:0] S_LATCH = 8'h40;
  localparam logic [7:0] S_DRD   = 8'h20;
  localparam logic [7:0] S_DWR   = 8'h10;
  localparam logic [7:0] S_RTRD  = 8'h0D;
  localparam logic [7:0] S_RTLD  = 8'h0F;
  localparam logic [7:0] S_RTPC  = 8'h09;

  stall4mem_ctrl_fsm #(
    .CNT_WIDTH      (8),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_ready_i (instr_ready_i),
    .dmem_ready_i  (dmem_ready_i),
    .instr_class_i (instr_class_i),
    .read_instr_o  (read_instr_o),
    .instr_latch_o (instr_latch_o),
    .dmem_read_o   (dmem_read_o),
    .dmem_write_o  (dmem_write_o),
    .pc_we_o       (pc_we_o),
    .rf_we_o       (rf_we_o),
    .rf_wsel_o     (rf_wsel_o),
    .instret_o     (instret_o),
    .trap_o        (trap_o),
    .timeout_o     (timeout_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o)
  );

  assign strobes = {read_instr_o, instr_latch_o, dmem_read_o, dmem_write_o,
                    pc_we_o, rf_we_o, rf_wsel_o, instret_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then advance.
  task automatic cyc(input logic ir, input logic dr, input logic [2:0] cls,
                     input logic [7:0] exp_s, input string tag);
    instr_ready_i = ir;
    dmem_ready_i  = dr;
    instr_class_i = cls;
    @(negedge clk);
    check({tag, " strobes"}, {24'd0, strobes}, {24'd0, exp_s});
    check({tag, " trap"}, {31'd0, trap_o}, {31'd0, exp_trap});
    check({tag, " timeout"}, {31'd0, timeout_o}, {31'd0, exp_timeout});
    @(posedge clk);
    #1;
    exp_cycle++;
    if (exp_s[0]) exp_instret++;
    check({tag, " cycle_cnt"}, {24'd0, cycle_cnt_o}, 32'(exp_cycle % 256));
    check({tag, " instret_cnt"}, {24'd0, instret_cnt_o}, 32'(exp_instret % 256));
  endtask

  // Reset is applied away from the clock edge so its effect is seen asynchronously.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    exp_cycle   = 0;
    exp_instret = 0;
    exp_trap    = 1'b0;
    exp_timeout = 1'b0;
    check("rst strobes", {25'd0, strobes[6:0]}, 32'd0);
    check("rst trap", {31'd0, trap_o}, 32'd0);
    check("rst timeout", {31'd0, timeout_o}, 32'd0);
    check("rst cycle_cnt", {24'd0, cycle_cnt_o}, 32'd0);
    check("rst instret_cnt", {24'd0, instret_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // ALU: retires in cycle 3
    cyc(0, 0, 3'd0, S_FREQ,  "alu c1");
    cyc(1, 0, 3'd0, S_LATCH, "alu c2");
    cyc(0, 0, 3'd0, S_RTRD,  "alu c3");
    check("alu instret_cnt", {24'd0, instret_cnt_o}, 32'd1);
    check("alu cycle_cnt", {24'd0, cycle_cnt_o}, 32'd3);

    // LOAD with data ready after 4 idle wait cycles: 9 cycles total
    cyc(0, 0, 3'd1, S_FREQ,  "ld fetch");
    cyc(1, 0, 3'd1, S_LATCH, "ld wait");
    cyc(0, 0, 3'd1, S_NONE,  "ld exec");
    cyc(0, 0, 3'd1, S_DRD,   "ld req");
    for (int i = 0; i < 4; i++) cyc(0, 0, 3'd1, S_NONE, "ld stall");
    cyc(0, 1, 3'd1, S_RTLD,  "ld done");

    // STORE with early ready in STORE_REQ that must be ignored
    cyc(0, 0, 3'd2, S_FREQ,  "st fetch");
    cyc(1, 0, 3'd2, S_LATCH, "st wait");
    cyc(0, 0, 3'd2, S_NONE,  "st exec");
    cyc(0, 1, 3'd2, S_DWR,   "st req");
    cyc(0, 0, 3'd2, S_NONE,  "st stall1");
    cyc(0, 0, 3'd2, S_NONE,  "st stall2");
    cyc(0, 1, 3'd2, S_RTPC,  "st done");

    // BRANCH with ready lines toggled where they must be ignored
    cyc(1, 1, 3'd3, S_FREQ,  "br fetch");
    cyc(0, 1, 3'd3, S_NONE,  "br stall");
    cyc(1, 0, 3'd3, S_LATCH, "br wait");
    cyc(0, 1, 3'd3, S_RTPC,  "br exec");

    cyc(0, 0, 3'd4, S_FREQ,  "jmp fetch");
    cyc(1, 0, 3'd4, S_LATCH, "jmp wait");
    cyc(0, 0, 3'd4, S_RTRD,  "jmp exec");
    cyc(0, 0, 3'd5, S_FREQ,  "up fetch");
    cyc(1, 0, 3'd5, S_LATCH, "up wait");
    cyc(0, 0, 3'd5, S_RTRD,  "up exec");
    check("seq instret_cnt", {24'd0, instret_cnt_o}, 32'd6);
    check("seq cycle_cnt", {24'd0, cycle_cnt_o}, 32'd29);

    // Ready on the 8th wait cycle completes the fetch
    cyc(0, 0, 3'd0, S_FREQ, "wd8 fetch");
    for (int i = 0; i < 7; i++) cyc(0, 0, 3'd0, S_NONE, "wd8 stall");
    cyc(1, 0, 3'd0, S_LATCH, "wd8 ready");
    cyc(0, 0, 3'd0, S_RTRD,  "wd8 exec");

`ifdef MEM_TIMEOUT_EN
    cyc(0, 0, 3'd0, S_FREQ, "wdto fetch");
    for (int i = 0; i < 8; i++) cyc(0, 0, 3'd0, S_NONE, "wdto stall");
    exp_trap    = 1'b1;
    exp_timeout = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 1, 3'd0, S_NONE, "wdto trapped");
    do_reset();
`else
    cyc(0, 0, 3'd0, S_FREQ, "nowd fetch");
    for (int i = 0; i < 100; i++) cyc(0, 0, 3'd0, S_NONE, "nowd stall");
    cyc(1, 0, 3'd0, S_LATCH, "nowd ready");
    cyc(0, 0, 3'd0, S_RTRD,  "nowd exec");
`endif

    // Illegal class traps until reset; cycle counter keeps running
    cyc(0, 0, 3'd6, S_FREQ,  "ill fetch");
    cyc(1, 0, 3'd6, S_LATCH, "ill wait");
    cyc(0, 0, 3'd6, S_NONE,  "ill exec");
    exp_trap = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1, 1, 3'd0, S_NONE, "ill trapped");
    do_reset();
    cyc(0, 0, 3'd0, S_FREQ,  "post trap fetch");

    // Reset in LOAD_WAIT drops the outstanding response
    cyc(1, 0, 3'd1, S_LATCH, "mid wait");
    cyc(0, 0, 3'd1, S_NONE,  "mid exec");
    cyc(0, 0, 3'd1, S_DRD,   "mid req");
    cyc(0, 0, 3'd1, S_NONE,  "mid stall");
    dmem_ready_i = 1'b1;
    do_reset();
    cyc(0, 1, 3'd1, S_FREQ,  "mid refetch");
    cyc(1, 1, 3'd0, S_LATCH, "mid rewait");
    cyc(0, 0, 3'd0, S_RTRD,  "mid reexec");

    // 300 ALU instructions with an 8-bit instret counter
    do_reset();
    for (int n = 0; n < 300; n++) begin
      cyc(0, 0, 3'd0, S_FREQ,  "wrap fetch");
      cyc(1, 0, 3'd0, S_LATCH, "wrap wait");
      cyc(0, 0, 3'd0, S_RTRD,  "wrap exec");
    end
    check("wrap instret_cnt", {24'd0, instret_cnt_o}, 32'd44);
    check("wrap cycle_cnt", {24'd0, cycle_cnt_o}, 32'd132);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
